snn_delay_layer_pipelined: RTL
==============================

// Module: snn_delay_layer_pipelined
// PURPOSE
//  Layer of N leaky integrate-and-fire neurons sharing M input spike lines, with programmable per-synapse axonal delays.
//  Next generation of our delayed neuron layer: parametrised weight/potential width and delay depth, signed weights,
//  a single shared spike-history buffer replacing per-neuron delay lines, saturating arithmetic and a step-valid strobe.
//  Sits between the input spike encoder (or the previous layer) and the output spike collector, clocked by the system clk.
// PARAMETERS
//  M   2  number of input spike lines / synapses per neuron
//  N   4  number of neurons
//  W   8  weight width, two's complement
//  PW  8  membrane potential width, unsigned
//  D   8  delay depth, power of two >= 2; delays 0..D-1 time steps; DW = $clog2(D)
// PORTS
//  clk                 in   1        system clock, rising edge
//  reset               in   1        asynchronous active-low reset
//  enable              in   1        time-step strobe; each clk with enable=1 is one time step
//  clear               in   1        synchronous flush of history, potentials, refractory counters and spikes
//  input_spikes        in   M        spikes for the current time step
//  weights             in   N*M*W    weight of neuron i, input j at [(i*M+j)*W +: W]
//  delay_values        in   N*M*DW   delay of synapse (i,j) at [(i*M+j)*DW +: DW]
//  delays              in   N*M      per-synapse delay enable; 0 means delay 0
//  threshold           in   PW       firing threshold
//  decay               in   PW       leak subtracted per step
//  refractory_period   in   8        refractory length in time steps
//  output_spikes       out  N        spike of each neuron for the last step
//  step_valid          out  1        1-cycle pulse: output_spikes/potentials updated
// BEHAVIOUR
//  Reset (reset=0, async): history, V[i], refr[i], output_spikes, step_valid all 0.
//  History: hist[j] holds D-1 bits. On step: hist[j] <= {hist[j][D-3:0], input_spikes[j]}; hist[j][k] = spike k+1 steps ago.
//  Tap: d = delays[i*M+j] ? delay_values[...] : 0; tap = (d==0) ? input_spikes[j] : hist[j][d-1].
//  Sum: S[i] = sum over j of (tap ? weight : 0), signed, width W+$clog2(M)+1, never overflows.
//  Per neuron on step, in order:
//   - refr[i] != 0: refr[i] -= 1; V[i] <= 0; spike 0.
//   - else L = (V > decay) ? V - decay : 0; T = L + S (signed, wide); T < 0 -> 0; T > 2^PW-1 -> 2^PW-1.
//   - if T >= threshold: spike 1; V <= 0; refr <= refractory_period. Else spike 0; V <= T.
//  Latency: output_spikes and step_valid registered, valid the cycle after the enable cycle.
//  output_spikes holds until the next step or clear. step_valid is high exactly 1 cycle per step.
//  Without enable: all state holds; step_valid 0.
//  clear=1: same effect as reset on the next edge; clear wins over a simultaneous enable. That step is discarded, no step_valid.
//  Boundaries:
//   - threshold=0 fires every non-refractory step.
//   - refractory_period=0: no refractory; the neuron may fire on consecutive steps.
//   - refractory_period=R blocks exactly R steps after a spike.
//   - Config inputs are sampled every step; changes mid-run take effect on the next step.
//   - Delays beyond the elapsed history after reset/clear read 0.
//   - Reset mid-step aborts the step; no partial update.
// CONFIGURATION
//  SNN_LAYER_DEBUG_EN defined: adds output port membrane_potential_out [N*PW-1:0].
//   - Neuron i's V at [i*PW +: PW], registered and updated together with output_spikes.
//   - Reads 0 after reset/clear.
//  Not defined: port absent. No potential observation logic; behaviour otherwise identical.
// TESTING
//  1. Defaults, w(0,0)=10, no delay, threshold=25, decay=0, spike in0 every step -> neuron0 fires on step 3, V: 10,20,0.
//  2. delays(0,0)=1, delay_values=3, single in0 pulse at step0, w=30, thr=25 -> fires step3 only; step_valid each step.
//  3. Refractory=2 with firing input every step -> spike pattern 1,0,0,1,0,0; V held 0 during refractory.
//  4. w=-5, V=3, decay=1 -> V=0 (clamp). w=127 on both inputs with V=250, thr=255 -> V saturates 255 and fires.
//  5. decay=4, V=10, no input -> V 6,2,0,0; enable=0 for 5 cycles -> V unchanged, no step_valid.
//  6. clear with enable in same cycle; then async reset low mid-run -> all outputs 0, history empty, delayed spikes lost.

Source files
------------

// File: rtl/snn_delay_layer_pipelined_if.sv
// Control/config/spike bus for the delayed LIF neuron layer.
// Optional macro SNN_LAYER_DEBUG_EN adds the membrane potential observation bus.
interface snn_delay_layer_pipelined_if #(
  parameter int M  = 2,
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int PW = 8,
  parameter int D  = 8
);
  localparam int DW = $clog2(D);

  logic                 enable;
  logic                 clear;
  logic [M-1:0]         input_spikes;
  logic [N*M*W-1:0]     weights;
  logic [N*M*DW-1:0]    delay_values;
  logic [N*M-1:0]       delays;
  logic [PW-1:0]        threshold;
  logic [PW-1:0]        decay;
  logic [7:0]           refractory_period;
  logic [N-1:0]         output_spikes;
  logic                 step_valid;
`ifdef SNN_LAYER_DEBUG_EN
  logic [N*PW-1:0]      membrane_potential_out;

  modport master (
    output enable, clear, input_spikes, weights, delay_values, delays,
           threshold, decay, refractory_period,
    input  output_spikes, step_valid, membrane_potential_out
  );
  modport slave (
    input  enable, clear, input_spikes, weights, delay_values, delays,
           threshold, decay, refractory_period,
    output output_spikes, step_valid, membrane_potential_out
  );
`else
  modport master (
    output enable, clear, input_spikes, weights, delay_values, delays,
           threshold, decay, refractory_period,
    input  output_spikes, step_valid
  );
  modport slave (
    input  enable, clear, input_spikes, weights, delay_values, delays,
           threshold, decay, refractory_period,
    output output_spikes, step_valid
  );
`endif
endinterface

// File: rtl/snn_delay_layer_pipelined.sv
// Layer of N leaky integrate-and-fire neurons with a shared spike-history buffer and per-synapse delays.
// Optional macro SNN_LAYER_DEBUG_EN exposes the membrane potentials on the interface.
module snn_delay_layer_pipelined #(
  parameter int M  = 2,
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int PW = 8,
  parameter int D  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  snn_delay_layer_pipelined_if.slave  bus
);
  localparam int DW = $clog2(D);
  localparam int SW = W + $clog2(M) + 1;
  localparam int TW = SW + PW + 2;
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-PW){1'b0}}, {PW{1'b1}}};

  // hist_reg[j][k] is the spike on line j from k+1 steps ago
  logic [D-2:0] hist_reg [M];
  logic         step_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < M; j++) hist_reg[j] <= '0;
      step_valid_reg <= 1'b0;
    end else if (bus.clear) begin
      for (int j = 0; j < M; j++) hist_reg[j] <= '0;
      step_valid_reg <= 1'b0;
    end else begin
      step_valid_reg <= bus.enable;
      if (bus.enable) begin
        for (int j = 0; j < M; j++) begin
          logic [D-1:0] shifted;
          shifted     = {hist_reg[j], bus.input_spikes[j]};
          hist_reg[j] <= shifted[D-2:0];
        end
      end
    end
  end

  assign bus.step_valid = step_valid_reg;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_neuron
    logic signed [SW-1:0] sum;
    logic signed [TW-1:0] total;
    logic [DW-1:0]        d;
    logic [DW-1:0]        dm1;
    logic                 tap;
    logic [W-1:0]         wt;
    logic [PW-1:0]        leak;
    logic [PW-1:0]        sat;
    logic [PW-1:0]        v_reg, v_next;
    logic [7:0]           refr_reg, refr_next;
    logic                 spike_reg, spike_next;

    always_comb begin
      sum = '0;
      d   = '0;
      dm1 = '0;
      tap = 1'b0;
      wt  = '0;
      for (int j = 0; j < M; j++) begin
        d   = bus.delays[gi*M+j] ? bus.delay_values[(gi*M+j)*DW +: DW] : '0;
        dm1 = d - DW'(1);
        tap = (d == '0) ? bus.input_spikes[j] : hist_reg[j][dm1];
        wt  = bus.weights[(gi*M+j)*W +: W];
        if (tap) sum = sum + {{(SW-W){wt[W-1]}}, wt};
      end

      leak  = (v_reg > bus.decay) ? v_reg - bus.decay : '0;
      total = {{(TW-PW){1'b0}}, leak} + {{(TW-SW){sum[SW-1]}}, sum};
      if (total < 0)             sat = '0;
      else if (total > SAT_MAX)  sat = '1;
      else                       sat = total[PW-1:0];

      v_next     = sat;
      refr_next  = refr_reg;
      spike_next = 1'b0;
      if (refr_reg != 8'd0) begin
        refr_next = refr_reg - 8'd1;
        v_next    = '0;
      end else if (sat >= bus.threshold) begin
        spike_next = 1'b1;
        v_next     = '0;
        refr_next  = bus.refractory_period;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_reg     <= '0;
        refr_reg  <= '0;
        spike_reg <= 1'b0;
      end else if (bus.clear) begin
        v_reg     <= '0;
        refr_reg  <= '0;
        spike_reg <= 1'b0;
      end else if (bus.enable) begin
        v_reg     <= v_next;
        refr_reg  <= refr_next;
        spike_reg <= spike_next;
      end
    end

    assign bus.output_spikes[gi] = spike_reg;
`ifdef SNN_LAYER_DEBUG_EN
    assign bus.membrane_potential_out[gi*PW +: PW] = v_reg;
`endif
  end
endmodule
